switch_conditioner: RTL

- Front-end stage for the logic processor.
- Takes raw asynchronous board switches and pushbuttons: execute, load_a, load_b.
- Synchronises each input to clk, inverts it if required, and debounces it.
- Presents a clean level per input; the execute level drives the control unit's execute input.
- Also presents one-cycle rise and fall pulses per input, for load strobes.

---
 rtl/switch_conditioner_pkg.sv | 18 +
 rtl/debounce_channel.sv | 101 ++++++++++
 rtl/switch_conditioner.sv | 45 ++++
 3 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared types and helpers for the switch front-end.
// Contents:
//   debounce_state - per-channel debounce FSM state
//   cnt_width()    - counter width for a given debounce length, never below 1
package switch_conditioner_pkg;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_ARM_HIGH,
    DB_HIGH,
    DB_ARM_LOW
  } debounce_state;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser chain followed by a debounce FSM.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   din    - asynchronous level, already polarity-corrected
//   level  - debounced level (high in DB_HIGH and DB_ARM_LOW)
//   rise   - one-cycle pulse when level goes 0->1
//   fall   - one-cycle pulse when level goes 1->0
module debounce_channel
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  debounce_state          state_q;
  logic [CntW-1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // level only changes on the two accepting transitions, so it is updated there
  // rather than decoded from state, keeping every output a plain flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DB_LOW;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state_q)
        DB_LOW: begin
          if (sync) begin
            state_q <= DB_ARM_HIGH;
            cnt_q   <= CntW'(1);
          end
        end
        DB_ARM_HIGH: begin
          if (!sync) begin
            // Any opposite sample throws away all progress.
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
            level   <= 1'b1;
            rise    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DB_HIGH: begin
          if (!sync) begin
            state_q <= DB_ARM_LOW;
            cnt_q   <= CntW'(1);
          end
        end
        DB_ARM_LOW: begin
          if (sync) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
            level   <= 1'b0;
            fall    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= DB_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Front-end conditioner for board switches and pushbuttons (execute, load_a, load_b).
// Each channel is polarity-corrected, synchronised to clk and debounced.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   raw_in     - asynchronous switch/button levels
//   clean_out  - debounced, active-high levels
//   rise_pulse - one-cycle pulse per channel when clean_out goes 0->1
//   fall_pulse - one-cycle pulse per channel when clean_out goes 1->0
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned           NUM_INPUTS      = 3,
  parameter int unsigned           SYNC_STAGES     = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 16,
  // Bit set = active-low input (e.g. DE2 KEYs).
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] clean_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse
);

  logic [NUM_INPUTS-1:0] active_in;

  assign active_in = raw_in ^ INVERT_MASK;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (active_in[i]),
      .level (clean_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule
